uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Serial boot-loader front end for the core's instruction memory. Receives 8N1 UART bytes from the host, parses a 4-byte little-endian word-count header, and forwards exactly 4×N payload bytes to the instruction memory loader port. It drives the memory's `loader_data`, `loader_ready` and `loader_enable` inputs, and signals completion to the rest of the core.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: CLK cycles per UART bit (100 MHz / 115200). Must be ≥ 8.
- `COUNT_WIDTH`, default 16: significant bits of the header word count. Header bits above this are ignored.

Ports:
- `CLK`, in, 1: clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `rx`, in, 1: asynchronous UART line; idle high.
- `loader_data`, out, 8: payload byte to the instruction memory.
- `loader_ready`, out, 1: one-cycle strobe; `loader_data` is valid this cycle.
- `loader_enable`, out, 1: high for the whole payload transfer.
- `load_done`, out, 1: one-cycle pulse when a load completes, including N=0.
- `frame_err`, out, 1: sticky framing-error flag; cleared only by reset.

## Operation

- **Synchroniser.** `rx` passes through 2 flip-flops. All logic uses the synchronised value `rxs`.
- **Receiver FSM: IDLE → START → DATA → STOP.**
  - IDLE: a falling edge of `rxs` loads the bit timer with CLKS_PER_BIT/2 − 1 and moves to START.
  - START: on timer expiry, if `rxs` is high it is a glitch and the FSM returns to IDLE. Otherwise it moves to DATA with timer CLKS_PER_BIT − 1.
  - DATA: samples 8 bits, one every CLKS_PER_BIT cycles, LSB first, into a shift register.
  - STOP: samples once. If high, it pulses internal `byte_valid` for 1 cycle and returns to IDLE that cycle. If low, it sets `frame_err`, discards the byte, asserts internal `byte_err` for 1 cycle, then waits for `rxs` high before returning to IDLE.
- **Loader FSM: HDR → PAY → TAIL.**
  - HDR: collects 4 valid bytes into the count, LSB first.
    - On the 4th byte with count[COUNT_WIDTH−1:0] == 0: pulse `load_done` and stay in HDR.
    - Otherwise: load the byte counter with count×4 (width COUNT_WIDTH+2), set `loader_enable`, and go to PAY.
  - PAY: each `byte_valid` registers the byte onto `loader_data`, pulses `loader_ready` the next cycle, and decrements the counter. When the counter reaches 0, go to TAIL.
  - TAIL: holds `loader_enable` high for 2 more cycles so the memory commits the final word. It then drops `loader_enable`, pulses `load_done`, and returns to HDR with the header byte index cleared.
- **Framing errors.**
  - `byte_err` in HDR: clears the header byte index.
  - `byte_err` in PAY: aborts the load. `loader_enable` drops the next cycle, the FSM returns to HDR, and there is no `load_done`.
- **Reset** (any state, mid-byte or mid-load) returns both FSMs to IDLE/HDR. Reset values:
  - `loader_data` = 0x00
  - `loader_ready` = 0
  - `loader_enable` = 0
  - `load_done` = 0
  - `frame_err` = 0
  - counters = 0

## Timing

- Latency from the falling edge on `rx` to `loader_ready` is 2 (sync) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT + 1 cycles.
- `loader_enable` rises the cycle after the 4th header `byte_valid`. It therefore leads the first `loader_ready` by at least 9 bit times.
- `loader_ready` is high exactly 1 cycle per payload byte.
- `loader_data` is stable from its `loader_ready` until the next `loader_ready`.
- The final `loader_ready` is at cycle T. `loader_enable` is high through T+2 and low at T+3. `load_done` is high at T+3 only.
- Back-to-back frames with no idle time are received without loss, because the receiver re-arms at the mid-stop sample.
- A new header may begin immediately after `load_done`. Bytes arriving during TAIL are impossible in practice (less than 1 bit time).

## Test plan

Benches run with CLKS_PER_BIT = 16 and COUNT_WIDTH = 16.

1. Header 01 00 00 00, then payload 11 22 33 44 → four `loader_ready` pulses carrying 0x11, 0x22, 0x33, 0x44. `loader_enable` rises the cycle after the header completes and falls 3 cycles after the 4th pulse. `load_done` pulses once; `frame_err` = 0.
2. Header 00 00 00 00 → `load_done` pulse the cycle after the 4th byte. `loader_enable` and `loader_ready` never assert.
3. `rx` held low for 4 cycles, then high → no byte, no strobes. A following valid 0x5A is received correctly.
4. Header N=1, 2 payload bytes, then a 3rd byte with its stop bit low → `frame_err` = 1, no `loader_ready` for that byte, `loader_enable` low the next cycle, no `load_done`. A fresh header N=0 still yields `load_done`.
5. Header N=2, reset asserted after 3 payload bytes → all outputs at reset values the cycle after reset. A new header 01 00 00 00 plus 4 bytes loads normally.
6. Header 02 00 00 00 plus 8 bytes sent back-to-back with no idle bits → 8 `loader_ready` pulses in order, one `load_done`.

Source files
------------

// File: rtl/uart_program_loader.sv
// UART boot loader front end: receives 8N1 bytes, parses a 4-byte LE word-count
// header and streams 4*N payload bytes onto the instruction memory loader port.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] loader_data,
    output logic       loader_ready,
    output logic       loader_enable,
    output logic       load_done,
    output logic       frame_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = COUNT_WIDTH + 2;
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {LD_HDR, LD_PAY, LD_TAIL} ld_state_t;

    logic            rx_meta, rxs;
    rx_state_t       rx_state, rx_state_d;
    logic [TW-1:0]   timer, timer_d;
    logic [2:0]      bit_idx, bit_idx_d;
    logic [7:0]      shreg, shreg_d;
    logic            byte_valid, byte_valid_d;
    logic            byte_err, byte_err_d;
    logic            frame_err_d;

    ld_state_t        ld_state, ld_state_d;
    logic [1:0]       hdr_idx, hdr_idx_d;
    logic [COUNT_WIDTH-1:0] cnt_acc, cnt_acc_d, hdr_acc;
    logic [BW-1:0]    byte_cnt, byte_cnt_d;
    logic [1:0]       tail_cnt, tail_cnt_d;
    logic [7:0]       loader_data_d;
    logic             loader_ready_d, loader_enable_d, load_done_d;

    // ---------------- receiver ----------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rx_state   <= RX_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rxs        <= rx_meta;
            rx_state   <= rx_state_d;
            timer      <= timer_d;
            bit_idx    <= bit_idx_d;
            shreg      <= shreg_d;
            byte_valid <= byte_valid_d;
            byte_err   <= byte_err_d;
            frame_err  <= frame_err_d;
        end
    end

    // IDLE is only ever entered with rxs high, so a low level there is a falling edge.
    always_comb begin
        rx_state_d   = rx_state;
        timer_d      = timer;
        bit_idx_d    = bit_idx;
        shreg_d      = shreg;
        byte_valid_d = 1'b0;
        byte_err_d   = 1'b0;
        frame_err_d  = frame_err;
        case (rx_state)
            RX_IDLE: begin
                if (!rxs) begin
                    rx_state_d = RX_START;
                    timer_d    = HALF_M1;
                end
            end
            RX_START: begin
                if (timer == '0) begin
                    if (rxs) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        timer_d    = FULL_M1;
                        bit_idx_d  = '0;
                    end
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            RX_DATA: begin
                if (timer == '0) begin
                    shreg_d   = {rxs, shreg[7:1]};
                    timer_d   = FULL_M1;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            RX_STOP: begin
                if (timer == '0) begin
                    if (rxs) begin
                        byte_valid_d = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        byte_err_d  = 1'b1;
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT;
                    end
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            RX_WAIT: begin
                if (rxs) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- loader ----------------
    // Header bits beyond COUNT_WIDTH fall off the shift and are ignored.
    assign hdr_acc = ((hdr_idx == 2'd0) ? '0 : cnt_acc) |
                     (COUNT_WIDTH'(shreg) << {hdr_idx, 3'b000});

    always_ff @(posedge CLK) begin
        if (reset) begin
            ld_state      <= LD_HDR;
            hdr_idx       <= '0;
            cnt_acc       <= '0;
            byte_cnt      <= '0;
            tail_cnt      <= '0;
            loader_data   <= 8'h00;
            loader_ready  <= 1'b0;
            loader_enable <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            ld_state      <= ld_state_d;
            hdr_idx       <= hdr_idx_d;
            cnt_acc       <= cnt_acc_d;
            byte_cnt      <= byte_cnt_d;
            tail_cnt      <= tail_cnt_d;
            loader_data   <= loader_data_d;
            loader_ready  <= loader_ready_d;
            loader_enable <= loader_enable_d;
            load_done     <= load_done_d;
        end
    end

    always_comb begin
        ld_state_d      = ld_state;
        hdr_idx_d       = hdr_idx;
        cnt_acc_d       = cnt_acc;
        byte_cnt_d      = byte_cnt;
        tail_cnt_d      = tail_cnt;
        loader_data_d   = loader_data;
        loader_ready_d  = 1'b0;
        loader_enable_d = loader_enable;
        load_done_d     = 1'b0;
        case (ld_state)
            LD_HDR: begin
                if (byte_err) begin
                    hdr_idx_d = '0;
                end else if (byte_valid) begin
                    cnt_acc_d = hdr_acc;
                    hdr_idx_d = hdr_idx + 2'd1;
                    if (hdr_idx == 2'd3) begin
                        if (hdr_acc == '0) begin
                            load_done_d = 1'b1;
                        end else begin
                            byte_cnt_d      = {hdr_acc, 2'b00};
                            loader_enable_d = 1'b1;
                            ld_state_d      = LD_PAY;
                        end
                    end
                end
            end
            LD_PAY: begin
                if (byte_err) begin
                    loader_enable_d = 1'b0;
                    hdr_idx_d       = '0;
                    ld_state_d      = LD_HDR;
                end else if (byte_valid) begin
                    loader_data_d  = shreg;
                    loader_ready_d = 1'b1;
                    byte_cnt_d     = byte_cnt - BW'(1);
                    if (byte_cnt == BW'(1)) begin
                        tail_cnt_d = '0;
                        ld_state_d = LD_TAIL;
                    end
                end
            end
            LD_TAIL: begin
                // Enable stays up two cycles past the last strobe so the final word commits.
                tail_cnt_d = tail_cnt + 2'd1;
                if (tail_cnt == 2'd2) begin
                    loader_enable_d = 1'b0;
                    load_done_d     = 1'b1;
                    hdr_idx_d       = '0;
                    ld_state_d      = LD_HDR;
                end
            end
            default: ld_state_d = LD_HDR;
        endcase
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table-driven loads, hand-written corner sequences
// and randomized loads checked against a byte-level loader model.
module tb_uart_program_loader;
    localparam int CPB = 16;
    localparam int CW  = 16;
    // rx fall to loader_ready in cycles; the +1 in checks converts from the cycle in
    // which rx is driven to the first clock edge that captures it.
    localparam int LAT = 2 + CPB/2 + 9*CPB + 1;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] loader_data;
    logic       loader_ready, loader_enable, load_done, frame_err;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .COUNT_WIDTH(CW)) dut (
        .CLK(CLK), .reset(reset), .rx(rx),
        .loader_data(loader_data), .loader_ready(loader_ready),
        .loader_enable(loader_enable), .load_done(load_done), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    int  done_cnt, rise_cnt, done_cyc, rise_cyc, fall_cyc, first_rdy_cyc, last_rdy_cyc;
    bit  prev_rdy = 1'b0, prev_en = 1'b0;

    always @(negedge CLK) begin
        if (loader_ready === 1'b1) begin
            n_chk++;
            if (prev_rdy) begin
                n_fail++;
                $display("FAIL ready_width: loader_ready high 2+ cycles at cycle %0d, required 1", cyc);
            end
            if (got_q.size() == 0) first_rdy_cyc = cyc;
            got_q.push_back(loader_data);
            last_rdy_cyc = cyc;
        end
        if (load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (loader_enable === 1'b1 && !prev_en) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (loader_enable === 1'b0 && prev_en) fall_cyc = cyc;
        prev_rdy = (loader_ready === 1'b1);
        prev_en  = (loader_enable === 1'b1);
    end

    // ---------------- reference model (byte level) ----------------
    logic [7:0]  exp_q[$];
    bit          m_pay = 1'b0;
    int          m_idx = 0, m_rem = 0;
    logic [31:0] m_hdr = '0;

    task automatic mdl_reset();
        m_pay = 1'b0; m_idx = 0; m_rem = 0;
        exp_q.delete();
    endtask

    task automatic mdl_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_pay = 1'b0;
            m_idx = 0;
        end else if (m_pay) begin
            exp_q.push_back(b);
            m_rem--;
            if (m_rem == 0) m_pay = 1'b0;
        end else begin
            m_hdr[8*m_idx +: 8] = b;
            if (m_idx == 3) begin
                m_idx = 0;
                if (m_hdr[CW-1:0] != 0) begin
                    m_pay = 1'b1;
                    m_rem = 4 * int'(m_hdr[CW-1:0]);
                end
            end else begin
                m_idx++;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm);
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clr_mon();
        @(posedge CLK); #1;
        got_q.delete();
        exp_q.delete();
        done_cnt = 0; rise_cnt = 0;
        done_cyc = -1; rise_cyc = -1; fall_cyc = -1; first_rdy_cyc = -1; last_rdy_cyc = -1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int last_start;

    task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
        rx = 1'b0;
        last_start = cyc;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = ok;
        repeat (CPB) @(negedge CLK);
        if (!ok) begin
            rx = 1'b1;
            repeat (CPB) @(negedge CLK);
        end
        rx = 1'b1;
        repeat (gap * CPB) @(negedge CLK);
        mdl_byte(b, ok);
    endtask

    task automatic send_hdr(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, gap);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] hdr;
        int          npay;
        int          bad;       // payload index sent with a low stop bit, -1 = none
        int          gap;       // idle bit times after each byte
        int          exp_rdy;
        int          exp_done;
        bit          exp_ferr;
    } vec_t;

    initial begin
        vec_t vt[8];
        int hs4, p0;
        vt[0] = '{32'h0000_0001,  4, -1, 1,  4, 1, 1'b0};
        vt[1] = '{32'h0000_0000,  0, -1, 1,  0, 1, 1'b0};
        vt[2] = '{32'h5A5A_0000,  0, -1, 1,  0, 1, 1'b0};
        vt[3] = '{32'h0000_0001,  3,  2, 1,  2, 0, 1'b1};
        vt[4] = '{32'h0000_0000,  0, -1, 1,  0, 1, 1'b1};
        vt[5] = '{32'h0000_0003, 12, -1, 2, 12, 1, 1'b1};
        vt[6] = '{32'h0000_0002,  8, -1, 0,  8, 1, 1'b1};
        vt[7] = '{32'h0001_0002,  8, -1, 0,  8, 1, 1'b1};

        // reset values
        reset = 1'b1;
        settle(4);
        chk("rst_data",   loader_data,   8'h00);
        chk("rst_ready",  loader_ready,  0);
        chk("rst_enable", loader_enable, 0);
        chk("rst_done",   load_done,     0);
        chk("rst_ferr",   frame_err,     0);
        reset = 1'b0;
        settle(4);

        // N=1 load with exact timing
        clr_mon();
        send_hdr(32'h0000_0001, 1);
        hs4 = last_start;
        send_byte(8'h11, 1'b1, 1);
        p0 = last_start;
        send_byte(8'h22, 1'b1, 1);
        send_byte(8'h33, 1'b1, 1);
        send_byte(8'h44, 1'b1, 1);
        settle(2*CPB);
        chk("t1_first_byte", (got_q.size() > 0) ? got_q[0] : 9'h100, 8'h11);
        chk_data("t1_data");
        chk("t1_en_rise",  rise_cyc, hs4 + LAT + 1);
        chk("t1_latency",  first_rdy_cyc, p0 + LAT + 1);
        chk("t1_en_fall",  fall_cyc, last_rdy_cyc + 3);
        chk("t1_done_cyc", done_cyc, last_rdy_cyc + 3);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_ferr",     frame_err, 0);

        // N=0 header
        clr_mon();
        send_hdr(32'h0000_0000, 1);
        hs4 = last_start;
        settle(2*CPB);
        chk("t2_done_cyc", done_cyc, hs4 + LAT + 1);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_rises",    rise_cnt, 0);
        chk("t2_ready",    got_q.size(), 0);

        // table-driven loads
        for (int t = 0; t < 8; t++) begin
            int bad_start;
            bad_start = -1;
            clr_mon();
            send_hdr(vt[t].hdr, vt[t].gap);
            for (int p = 0; p < vt[t].npay; p++) begin
                bit ok;
                ok = (p != vt[t].bad);
                if (!ok) begin
                    send_byte(8'($urandom_range(0, 255)), 1'b0, vt[t].gap);
                    bad_start = last_start;
                end else begin
                    send_byte(8'($urandom_range(0, 255)), 1'b1, vt[t].gap);
                end
            end
            settle(3*CPB);
            chk($sformatf("vec%0d_ready", t), got_q.size(), vt[t].exp_rdy);
            chk_data($sformatf("vec%0d_data", t));
            chk($sformatf("vec%0d_done", t), done_cnt, vt[t].exp_done);
            chk($sformatf("vec%0d_rises", t), rise_cnt, (vt[t].hdr[CW-1:0] != 0) ? 1 : 0);
            chk($sformatf("vec%0d_ferr", t), frame_err, vt[t].exp_ferr);
            chk($sformatf("vec%0d_en_low", t), loader_enable, 0);
            if (bad_start >= 0)
                chk($sformatf("vec%0d_abort_cyc", t), fall_cyc, bad_start + LAT + 1);
        end

        // start-bit glitch during payload, then a real 0x5A
        clr_mon();
        send_hdr(32'h0000_0001, 1);
        rx = 1'b0;
        repeat (4) @(negedge CLK);
        rx = 1'b1;
        repeat (3*CPB) @(negedge CLK);
        chk("t3_glitch_ready", got_q.size(), 0);
        send_byte(8'h5A, 1'b1, 1);
        send_byte(8'h01, 1'b1, 1);
        send_byte(8'h02, 1'b1, 1);
        send_byte(8'h03, 1'b1, 1);
        settle(2*CPB);
        chk("t3_first_byte", (got_q.size() > 0) ? got_q[0] : 9'h100, 8'h5A);
        chk_data("t3_data");
        chk("t3_done_cnt", done_cnt, 1);

        // reset in the middle of a load
        clr_mon();
        send_hdr(32'h0000_0002, 1);
        for (int p = 0; p < 3; p++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1);
        @(negedge CLK);
        reset = 1'b1;
        mdl_reset();
        @(posedge CLK); #1;
        chk("t5_rst_data",   loader_data,   8'h00);
        chk("t5_rst_ready",  loader_ready,  0);
        chk("t5_rst_enable", loader_enable, 0);
        chk("t5_rst_done",   load_done,     0);
        chk("t5_rst_ferr",   frame_err,     0);
        reset = 1'b0;
        clr_mon();
        send_hdr(32'h0000_0001, 1);
        for (int p = 0; p < 4; p++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1);
        settle(2*CPB);
        chk_data("t5_data");
        chk("t5_done_cnt", done_cnt, 1);

        // randomized loads: random N, ignored header high bits, random gaps
        for (int r = 0; r < 6; r++) begin
            int n, gap;
            n   = $urandom_range(1, 3);
            gap = $urandom_range(0, 1);
            clr_mon();
            send_hdr({16'($urandom), 16'(n)}, gap);
            for (int p = 0; p < 4*n; p++) send_byte(8'($urandom_range(0, 255)), 1'b1, gap);
            settle(2*CPB);
            chk($sformatf("rnd%0d_ready", r), got_q.size(), 4*n);
            chk_data($sformatf("rnd%0d_data", r));
            chk($sformatf("rnd%0d_done", r), done_cnt, 1);
            chk($sformatf("rnd%0d_en_low", r), loader_enable, 0);
        end
        chk("final_ferr", frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
